// File: rtl/road_scroll_tracker.sv
// Per-frame speed integrator producing road scroll offset, travelled distance and finish strobe.
// Optional BCD odometer output is built when ODOMETER_BCD_EN is defined.
module road_scroll_tracker #(
  parameter int unsigned SUBPIX_BITS   = 3,
  parameter int unsigned ROAD_HEIGHT   = 480,
  parameter int unsigned PIX_PER_METER = 8,
  parameter int unsigned TRACK_LEN     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [4:0]  speed,
  input  logic        game_run,
  input  logic        restart,
  output logic [9:0]  scroll_y,
  output logic [15:0] distance,
  output logic        finish_pulse,
  output logic        running
`ifdef ODOMETER_BCD_EN
  ,
  output logic [15:0] distance_bcd
`endif
);

  localparam int unsigned SUM_W = ((SUBPIX_BITS > 5) ? SUBPIX_BITS : 5) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISHED} state_t;

  state_t                 state_q, state_d;
  logic                   sof_q, tick_q, tick_d;
  logic [SUBPIX_BITS-1:0] frac_q, frac_d;
  logic [9:0]             scroll_q, scroll_d;
  logic [15:0]            pix_q, pix_d;
  logic [15:0]            dist_q, dist_d;
  logic                   fin_q, fin_d;
  logic                   run_q;
  logic [SUM_W-1:0]       sum, px;
  logic [10:0]            scroll_sum;
  logic [16:0]            pix_sum;
`ifdef ODOMETER_BCD_EN
  logic [15:0]            bcd_q, bcd_d;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction
`endif

  // The tick is registered so the update lands one edge after the strobe rise.
  always_comb begin
    tick_d     = startOfFrame & ~sof_q;
    sum        = SUM_W'(frac_q) + SUM_W'(speed);
    px         = sum >> SUBPIX_BITS;
    scroll_sum = 11'(scroll_q) + 11'(px);
    pix_sum    = 17'(pix_q) + 17'(px);

    state_d  = state_q;
    frac_d   = frac_q;
    scroll_d = scroll_q;
    pix_d    = pix_q;
    dist_d   = dist_q;
    fin_d    = 1'b0;
`ifdef ODOMETER_BCD_EN
    bcd_d    = bcd_q;
`endif

    if (restart) begin
      state_d  = S_IDLE;
      frac_d   = '0;
      scroll_d = '0;
      pix_d    = '0;
      dist_d   = '0;
`ifdef ODOMETER_BCD_EN
      bcd_d    = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (game_run) state_d = S_RUN;
        end
        S_RUN: begin
          if (!game_run) begin
            state_d = S_IDLE;
          end else if (tick_q) begin
            frac_d   = sum[SUBPIX_BITS-1:0];
            scroll_d = (scroll_sum >= 11'(ROAD_HEIGHT)) ? 10'(scroll_sum - 11'(ROAD_HEIGHT))
                                                       : 10'(scroll_sum);
            if (pix_sum >= 17'(PIX_PER_METER)) begin
              pix_d  = 16'(pix_sum - 17'(PIX_PER_METER));
              dist_d = dist_q + 16'd1;
`ifdef ODOMETER_BCD_EN
              bcd_d  = bcd_inc(bcd_q);
`endif
              if (dist_d == 16'(TRACK_LEN)) begin
                state_d = S_FINISHED;
                fin_d   = 1'b1;
              end
            end else begin
              pix_d = 16'(pix_sum);
            end
          end
        end
        S_FINISHED: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sof_q    <= 1'b0;
      tick_q   <= 1'b0;
      frac_q   <= '0;
      scroll_q <= '0;
      pix_q    <= '0;
      dist_q   <= '0;
      fin_q    <= 1'b0;
      run_q    <= 1'b0;
`ifdef ODOMETER_BCD_EN
      bcd_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sof_q    <= startOfFrame;
      tick_q   <= tick_d;
      frac_q   <= frac_d;
      scroll_q <= scroll_d;
      pix_q    <= pix_d;
      dist_q   <= dist_d;
      fin_q    <= fin_d;
      run_q    <= (state_d == S_RUN);
`ifdef ODOMETER_BCD_EN
      bcd_q    <= bcd_d;
`endif
    end
  end

  assign scroll_y     = scroll_q;
  assign distance     = dist_q;
  assign finish_pulse = fin_q;
  assign running      = run_q;
`ifdef ODOMETER_BCD_EN
  assign distance_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_road_scroll_tracker.sv
// Directed + randomized bench for road_scroll_tracker; two instances (long track and TRACK_LEN=4).
module tb_road_scroll_tracker;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, game_run, restart;
  logic [4:0]  speed;
  logic [9:0]  scroll1, scroll2;
  logic [15:0] dist1, dist2;
  logic        fin1, fin2, run1, run2;
`ifdef ODOMETER_BCD_EN
  logic [15:0] bcd1, bcd2;
`endif

  int checks = 0;
  int failures = 0;
  int pulses2 = 0;
  int pulses1 = 0;

  int unsigned acc [2];
  bit          mfin[2];
  bit          jf  [2];
  int unsigned tl  [2] = '{1000, 4};

  road_scroll_tracker #(.TRACK_LEN(1000)) dut1 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .speed(speed),
    .game_run(game_run), .restart(restart), .scroll_y(scroll1), .distance(dist1),
    .finish_pulse(fin1), .running(run1)
`ifdef ODOMETER_BCD_EN
    , .distance_bcd(bcd1)
`endif
  );

  road_scroll_tracker #(.TRACK_LEN(4)) dut2 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .speed(speed),
    .game_run(game_run), .restart(restart), .scroll_y(scroll2), .distance(dist2),
    .finish_pulse(fin2), .running(run2)
`ifdef ODOMETER_BCD_EN
    , .distance_bcd(bcd2)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fin1 === 1'b1) pulses1++;
    if (fin2 === 1'b1) pulses2++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: total sub-pixel travel since the last clear; everything else derives from it.
  function automatic int unsigned mscroll(input int k);
    return (acc[k] >> 3) % 480;
  endfunction

  function automatic int unsigned mdist(input int k);
    int unsigned d;
    d = (acc[k] >> 3) / 8;
    return (d > tl[k]) ? tl[k] : d;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned d);
    return {4'(d / 1000 % 10), 4'(d / 100 % 10), 4'(d / 10 % 10), 4'(d % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      acc[k]  = 0;
      mfin[k] = 0;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick_clk(1);
    restart = 1'b0;
    model_clear();
    chk("restart_scroll", {22'd0, scroll1}, 0);
    chk("restart_dist", {16'd0, dist2}, 0);
    tick_clk(1);
  endtask

  task automatic frame(input int hold);
    logic [9:0] pre1, pre2;
    logic       fpa, fpb;
    pre1 = '0; pre2 = '0; fpa = 1'b0; fpb = 1'b0;
    for (int i = 0; i < hold + 2; i++) begin
      startOfFrame = (i < hold);
      tick_clk(1);
      if (i == 0) begin pre1 = scroll1; pre2 = scroll2; end
      if (i == 1) begin fpa = fin1; fpb = fin2; end
    end
    chk("latency1", {22'd0, pre1}, mscroll(0));
    chk("latency2", {22'd0, pre2}, mscroll(1));
    for (int k = 0; k < 2; k++) begin
      jf[k] = 0;
      if (game_run && !mfin[k]) begin
        acc[k] += speed;
        if ((acc[k] >> 3) / 8 >= tl[k]) begin
          mfin[k] = 1;
          jf[k]   = 1;
        end
      end
    end
    chk("scroll1", {22'd0, scroll1}, mscroll(0));
    chk("dist1", {16'd0, dist1}, mdist(0));
    chk("scroll2", {22'd0, scroll2}, mscroll(1));
    chk("dist2", {16'd0, dist2}, mdist(1));
    chk("fpulse1", {31'd0, fpa}, {31'd0, jf[0]});
    chk("fpulse2", {31'd0, fpb}, {31'd0, jf[1]});
    chk("running1", {31'd0, run1}, {31'd0, game_run && !mfin[0]});
`ifdef ODOMETER_BCD_EN
    chk("bcd1", {16'd0, bcd1}, {16'd0, to_bcd(mdist(0))});
`endif
  endtask

  initial begin
    int p0;
    reset = 1'b1; startOfFrame = 1'b0; game_run = 1'b0; restart = 1'b0; speed = 5'd20;
    model_clear();
    tick_clk(3);
    chk("rst_scroll", {22'd0, scroll1}, 0);
    chk("rst_dist", {16'd0, dist1}, 0);
    chk("rst_fpulse", {31'd0, fin1}, 0);
    chk("rst_running", {31'd0, run1}, 0);
`ifdef ODOMETER_BCD_EN
    chk("rst_bcd", {16'd0, bcd1}, 0);
`endif
    reset = 1'b0;
    tick_clk(2);

    // Idle: frames ignored while game_run is low
    for (int f = 0; f < 5; f++) frame(1);
    chk("idle_scroll", {22'd0, scroll1}, 0);
    chk("idle_running", {31'd0, run1}, 0);

    // Integer speed, plus running latency
    game_run = 1'b1;
    chk("run_before", {31'd0, run1}, 0);
    tick_clk(1);
    chk("run_after", {31'd0, run1}, 1);
    speed = 5'd8;
    for (int f = 0; f < 10; f++) frame(1);
    chk("int_scroll", {22'd0, scroll1}, 10);
    chk("int_dist", {16'd0, dist1}, 1);

    // Fractional carry
    do_restart();
    speed = 5'd12;
    frame(2);
    chk("frac_f1", {22'd0, scroll1}, 1);
    frame(1);
    chk("frac_f2", {22'd0, scroll1}, 3);

    // Wrap with stretched strobe; dut2 finishes along the way
    do_restart();
    speed = 5'd16;
    p0 = pulses2;
    for (int f = 0; f < 240; f++) frame(3);
    chk("wrap_scroll", {22'd0, scroll1}, 0);
    chk("wrap_dist", {16'd0, dist1}, 60);
`ifdef ODOMETER_BCD_EN
    chk("wrap_bcd", {16'd0, bcd1}, 32'h0060);
`endif
    chk("wrap_pulses2", pulses2 - p0, 1);

    // Finish on the short track
    do_restart();
    p0 = pulses2;
    for (int f = 0; f < 16; f++) frame(1);
    chk("fin_dist", {16'd0, dist2}, 4);
    chk("fin_pulses", pulses2 - p0, 1);
    for (int f = 0; f < 5; f++) frame(2);
    chk("fin_hold_scroll", {22'd0, scroll2}, 32);
    chk("fin_hold_dist", {16'd0, dist2}, 4);
    chk("fin_no_extra", pulses2 - p0, 1);
    chk("fin_running2", {31'd0, run2}, 0);

    // Pause, then restart coincident with a tick while running
    do_restart();
    for (int f = 0; f < 3; f++) frame(1);
    chk("pause_pre", {22'd0, scroll1}, 6);
    game_run = 1'b0;
    tick_clk(2);
    for (int f = 0; f < 4; f++) frame(1);
    chk("pause_scroll", {22'd0, scroll1}, 6);
    chk("pause_running", {31'd0, run1}, 0);
    game_run = 1'b1;
    tick_clk(2);
    startOfFrame = 1'b1;
    tick_clk(1);
    restart = 1'b1;
    game_run = 1'b0;
    tick_clk(1);
    restart = 1'b0;
    startOfFrame = 1'b0;
    model_clear();
    chk("rtick_scroll", {22'd0, scroll1}, 0);
    chk("rtick_dist", {16'd0, dist1}, 0);
    chk("rtick_fpulse", {31'd0, fin1}, 0);
    chk("rtick_running", {31'd0, run1}, 0);
    tick_clk(2);

    // Randomized run with pauses and restarts
    game_run = 1'b1;
    tick_clk(2);
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        game_run = ~game_run;
        tick_clk(2);
      end
      if ($urandom_range(0, 14) == 0) do_restart();
      speed = 5'($urandom_range(0, 31));
      frame(int'($urandom_range(1, 3)));
    end
    chk("rand_pulses1", pulses1, 0);

    // Asynchronous reset between clock edges
    game_run = 1'b1;
    speed = 5'd31;
    tick_clk(2);
    frame(1);
    #2 reset = 1'b1;
    #1;
    chk("areset_scroll", {22'd0, scroll1}, 0);
    chk("areset_dist", {16'd0, dist2}, 0);
    chk("areset_running", {31'd0, run1}, 0);
    tick_clk(1);
    reset = 1'b0;
    tick_clk(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/road_scroll_tracker.md
# road_scroll_tracker

Converts the per-frame `speed` value from the speed manager into vertical road scroll and travelled distance. It sits directly downstream of the speed manager and feeds the road/background drawer (`scroll_y`) and the HUD/game controller (`distance`, `finish_pulse`). Once per frame it integrates speed with sub-pixel precision and wraps the scroll offset at the road bitmap height. It detects the end of the track and signals it.

## Interface
Parameters:
- `SUBPIX_BITS`, 3: fractional bits of the speed-to-pixel integrator; pixels/frame = speed / 2^SUBPIX_BITS.
- `ROAD_HEIGHT`, 480: scroll wrap modulus in pixels.
- `PIX_PER_METER`, 8: pixels per distance unit; must exceed 31 >> SUBPIX_BITS.
- `TRACK_LEN`, 1000: distance at which the race finishes; must be at most 65535.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `startOfFrame` in 1: frame strobe, synchronous to `clk`; may be high for more than one cycle.
- `speed` in 5: current speed from the speed manager, unsigned.
- `game_run` in 1: level-sensitive enable; low pauses the block.
- `restart` in 1: synchronous clear pulse.
- `scroll_y` out 10: road offset, 0..ROAD_HEIGHT-1.
- `distance` out 16: distance units travelled, saturates at TRACK_LEN.
- `finish_pulse` out 1: one-`clk` pulse when TRACK_LEN is reached.
- `running` out 1: high in RUN state.
- `distance_bcd` out 16: 4-digit BCD of `distance`; present only with ODOMETER_BCD_EN.

## Operation
- Frame tick: `tick = startOfFrame & ~sof_d`, where `sof_d` is `startOfFrame` registered. A strobe held high for several cycles counts once.
- FSM states:
  - IDLE to RUN on `game_run`=1.
  - RUN to IDLE on `game_run`=0.
  - RUN to FINISHED when distance reaches TRACK_LEN.
  - FINISHED holds until `restart` or `reset`.
- `restart`, any state: clears `frac`, `scroll_y`, `pix_cnt`, `distance`, BCD; next state is IDLE. `restart` has priority over `tick`.
- On `tick` in RUN:
  - `sum = frac + speed`, 6 bits. `px = sum >> SUBPIX_BITS`. `frac <= sum[SUBPIX_BITS-1:0]`.
  - `scroll_y <= (scroll_y + px >= ROAD_HEIGHT) ? scroll_y + px - ROAD_HEIGHT : scroll_y + px`.
  - `pix_cnt + px >= PIX_PER_METER`: subtract PIX_PER_METER and increment `distance`. At most one increment per frame.
  - If the increment makes `distance == TRACK_LEN`: go to FINISHED and assert `finish_pulse` for one cycle. `scroll_y` still takes this frame's `px`.
- IDLE and FINISHED: all state is frozen; ticks are ignored.
- `speed`=0: no motion; `frac` is unchanged.

## Timing
- Reset values: `scroll_y`=0, `distance`=0, `finish_pulse`=0, `running`=0, `distance_bcd`=0. Internally `frac`=0, `pix_cnt`=0, `sof_d`=0, state IDLE.
- Rising `startOfFrame` sampled at clk edge N: updated outputs are visible after edge N+1. Latency is 2 edges from the strobe rise.
- `finish_pulse` is high exactly in the cycle after the update edge that reached TRACK_LEN.
- `running` is registered from the state and follows `game_run` with 1 cycle of latency.
- `speed` is sampled only on the tick edge; changes between ticks have no effect.
- Reset assertion mid-frame clears immediately and asynchronously. Reset release is synchronous to `clk`.

## Configuration
- `ODOMETER_BCD_EN` defined:
  - A 4-digit BCD counter increments in lockstep with `distance`, with decimal carry 9 to 0.
  - It is cleared by `reset` and `restart`, saturates with `distance`, and drives `distance_bcd`.
- `ODOMETER_BCD_EN` undefined: the `distance_bcd` port and its logic are absent.

## Test plan
Defaults unless stated: SUBPIX_BITS=3, ROAD_HEIGHT=480, PIX_PER_METER=8.
- Reset and idle: assert `reset`, then pulse 5 frames with `game_run`=0 and `speed`=20. Required: `scroll_y`=0, `distance`=0, `running`=0.
- Integer speed: `game_run`=1, `speed`=8, 10 frames. Required: `scroll_y`=10, `distance`=1.
- Fractional carry: `speed`=12. Required: `scroll_y`=1 after frame 1 and 3 after frame 2.
- Wrap and stretched strobe: `speed`=16, 240 frames with each `startOfFrame` held high 3 cycles. Required: `scroll_y`=0 (480 wrapped), `distance`=60; with BCD enabled, `distance_bcd`=0x0060.
- Finish: TRACK_LEN=4, `speed`=16, 16 frames. Required: `distance`=4 and exactly one `finish_pulse`; then 5 more frames leave `scroll_y`=32 and `distance`=4.
- Pause and restart: run `speed`=16 for 3 frames to reach `scroll_y`=6; drop `game_run` for 4 frames and `scroll_y` stays 6. Then `restart` coincident with a tick. Required: all outputs 0, state IDLE.
